// File: rtl/as_pkg.sv
// Shared types and field positions for the accumulator-processor sequencer.
// Imported by the decoder, the fetch interface and the sequencer top.
package as_pkg;

  localparam int INSTR_W = 16;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 11;
  localparam int RS_MSB  = 10;
  localparam int RS_LSB  = 9;
  localparam int RSV_BIT = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [7:0] BSW_IMM = 8'h01;

  typedef enum logic [2:0] {
    OP_JMP  = 3'b000,
    OP_ADDI = 3'b001,
    OP_MACI = 3'b010,
    OP_IN   = 3'b011,
    OP_ACCI = 3'b100,
    OP_OUT  = 3'b101,
    OP_BZ   = 3'b110,
    OP_BSW  = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  // Source of the immediate port during EXEC.
  typedef enum logic [1:0] {
    IMM_IR   = 2'd0,
    IMM_ZERO = 2'd1,
    IMM_BSW  = 2'd2
  } imm_sel_t;

  typedef struct packed {
    logic     add_a_sel;
    logic     add_b_sel;
    logic     acc_en;
    logic     acc_add;
    logic     in_en;
    logic     reg_we;
    logic     jump;      // unconditional pc <= imm
    logic     branch;    // pc <= imm when z
    imm_sel_t imm_sel;
  } ctrl_t;

endpackage

// File: rtl/as_sequencer_if.sv
// Program-memory fetch handshake: request/address out, ack/instruction back.
interface as_sequencer_if
  import as_pkg::*;
#(
  parameter int p = 8
);

  logic               req;
  logic [p-1:0]       addr;
  logic               ack;
  logic [INSTR_W-1:0] data;

  modport master (output req, addr, input  ack, data);
  modport slave  (input  req, addr, output ack, data);

endinterface

// File: rtl/as_decode.sv
// Purely combinational opcode decoder producing the EXEC-cycle control bundle.
module as_decode
  import as_pkg::*;
(
  input  opcode_t opcode,
  output ctrl_t   ctrl
);

  always_comb begin
    // NOTE: default every field first so no opcode path leaves ctrl unassigned (no latch).
    ctrl         = '0;
    ctrl.imm_sel = IMM_IR;
    unique case (opcode)
      OP_JMP:  ctrl.jump = 1'b1;
      OP_ADDI: begin
        ctrl.add_b_sel = 1'b1;
        ctrl.reg_we    = 1'b1;
      end
      OP_MACI: ctrl.reg_we = 1'b1;
      OP_IN: begin
        ctrl.in_en  = 1'b1;
        ctrl.reg_we = 1'b1;
      end
      OP_ACCI: begin
        ctrl.acc_add   = 1'b1;
        ctrl.add_b_sel = 1'b1;
        ctrl.acc_en    = 1'b1;
      end
      OP_OUT: begin
        ctrl.add_b_sel = 1'b1;
        ctrl.acc_en    = 1'b1;
      end
      OP_BZ: begin
        ctrl.add_b_sel = 1'b1;
        ctrl.branch    = 1'b1;
        ctrl.imm_sel   = IMM_ZERO;
      end
      OP_BSW: begin
        ctrl.add_a_sel = 1'b1;
        ctrl.add_b_sel = 1'b1;
        ctrl.branch    = 1'b1;
        ctrl.imm_sel   = IMM_BSW;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/as_sequencer.sv
// Fetch/execute sequencer: owns the pc, fetches over a req/ack port and
// drives datapath controls for exactly one EXEC cycle per instruction.
module as_sequencer
  import as_pkg::*;
#(
  parameter int n = 8,
  parameter int p = 8
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  as_sequencer_if.master      imem,
  input  logic                z,
  output logic [1:0]          rd_addr,
  output logic [1:0]          rs_addr,
  output logic [n-1:0]        immediate,
  output logic                add_a_sel,
  output logic                add_b_sel,
  output logic                acc_en,
  output logic                acc_add,
  output logic                in_en,
  output logic                reg_we,
  output logic                busy
);

  state_t             state;
  logic [p-1:0]       pc;
  logic [INSTR_W-1:0] ir;
  logic               req_q;

  opcode_t            opcode;
  ctrl_t              dec;
  logic [7:0]         ir_imm;
  logic               take_branch;
  logic               exec;
  logic               reserved_unused;

  assign opcode          = opcode_t'(ir[OPC_MSB:OPC_LSB]);
  assign ir_imm          = ir[IMM_MSB:IMM_LSB];
  assign reserved_unused = ir[RSV_BIT];
  assign exec            = (state == EXEC);

  as_decode u_decode (
    .opcode (opcode),
    .ctrl   (dec)
  );

  // Branch target always comes from the IR, never from the forced immediate.
  assign take_branch = dec.jump | (dec.branch & z);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking everywhere so every flop samples pre-edge values.
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      ir    <= '0;
      req_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (run) begin
            state <= FETCH;
            req_q <= 1'b1;
          end
        end
        FETCH: begin
          // A run drop here is ignored; the fetch always completes.
          if (imem.ack) begin
            ir    <= imem.data;
            state <= EXEC;
            req_q <= 1'b0;
          end
        end
        EXEC: begin
          pc    <= take_branch ? p'(ir_imm) : pc + p'(1);
          state <= run ? FETCH : IDLE;
          req_q <= run;
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem.req  = req_q;
  assign imem.addr = pc;
  assign busy      = (state != IDLE);

  // Controls, addresses and immediate are all held at 0 outside EXEC.
  always_comb begin
    rd_addr   = '0;
    rs_addr   = '0;
    immediate = '0;
    add_a_sel = 1'b0;
    add_b_sel = 1'b0;
    acc_en    = 1'b0;
    acc_add   = 1'b0;
    in_en     = 1'b0;
    reg_we    = 1'b0;
    if (exec) begin
      rd_addr   = ir[RD_MSB:RD_LSB];
      rs_addr   = ir[RS_MSB:RS_LSB];
      add_a_sel = dec.add_a_sel;
      add_b_sel = dec.add_b_sel;
      acc_en    = dec.acc_en;
      acc_add   = dec.acc_add;
      in_en     = dec.in_en;
      reg_we    = dec.reg_we;
      unique case (dec.imm_sel)
        IMM_ZERO: immediate = '0;
        IMM_BSW:  immediate = n'(BSW_IMM);
        default:  immediate = n'(ir_imm);
      endcase
    end
  end

endmodule

// File: tb/tb_as_sequencer.sv
// Self-checking bench for as_sequencer: directed program walk plus randomized
// instructions, ack delays and run drops against a pc/control reference model.
module tb_as_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic run;
  logic z;
  logic [1:0] rd_addr, rs_addr;
  logic [7:0] immediate;
  logic add_a_sel, add_b_sel, acc_en, acc_add, in_en, reg_we, busy;

  always #5 clk = ~clk;

  as_sequencer_if #(.p(8)) imem ();

  as_sequencer #(.n(8), .p(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .imem      (imem.master),
    .z         (z),
    .rd_addr   (rd_addr),
    .rs_addr   (rs_addr),
    .immediate (immediate),
    .add_a_sel (add_a_sel),
    .add_b_sel (add_b_sel),
    .acc_en    (acc_en),
    .acc_add   (acc_add),
    .in_en     (in_en),
    .reg_we    (reg_we),
    .busy      (busy)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] mem [256];
  logic [7:0]  exp_pc;

  // Per-opcode EXEC controls {add_a_sel, add_b_sel, acc_en, acc_add, in_en, reg_we}.
  localparam logic [5:0] CTL_TBL [8] = '{
    6'b000000,  // JMP
    6'b010001,  // ADDI
    6'b000001,  // MACI
    6'b000011,  // IN
    6'b011100,  // ACCI
    6'b011000,  // OUT
    6'b010000,  // BZ
    6'b110000   // BSW
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ctl_vec();
    return 32'({rd_addr, rs_addr, immediate, add_a_sel, add_b_sel, acc_en, acc_add, in_en, reg_we});
  endfunction

  function automatic logic [31:0] exp_ctl(input logic [15:0] w);
    int         op;
    logic [7:0] imm;
    op  = int'(w[15:13]);
    imm = (op == 6) ? 8'h00 : (op == 7) ? 8'h01 : w[7:0];
    return 32'({w[12:11], w[10:9], imm, CTL_TBL[op]});
  endfunction

  function automatic logic [7:0] next_pc(input logic [15:0] w, input logic [7:0] pc,
                                         input logic zv);
    int op;
    op = int'(w[15:13]);
    if (op == 0)            return w[7:0];
    if (op >= 6 && zv)      return w[7:0];
    return pc + 8'd1;
  endfunction

  function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int imm);
    logic [15:0] w;
    w = {3'(op), 2'(rd), 2'(rs), 1'($urandom), 8'(imm)};
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input string tag);
    check({tag, "_req"},  32'(imem.req),  32'd1);
    check({tag, "_addr"}, 32'(imem.addr), 32'(exp_pc));
    check({tag, "_ctl"},  ctl_vec(),      32'd0);
    check({tag, "_busy"}, 32'(busy),      32'd1);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_req"},  32'(imem.req), 32'd0);
    check({tag, "_busy"}, 32'(busy),     32'd0);
    check({tag, "_ctl"},  ctl_vec(),     32'd0);
  endtask

  // Precondition: DUT is in FETCH this cycle with run high.
  task automatic exec_instr(input int waits, input logic zv, input bit drop_in_fetch,
                            input bit run_after);
    logic [15:0] w;
    for (int i = 0; i < waits; i++) begin
      expect_fetch("fetch_wait");
      if (drop_in_fetch) run = 1'b0;
      imem.ack  = 1'b0;
      imem.data = 16'($urandom);
      z         = 1'($urandom);
      tick();
    end
    expect_fetch("fetch_ack");
    if (drop_in_fetch) run = 1'b0;
    w         = mem[exp_pc];
    imem.ack  = 1'b1;
    imem.data = w;
    z         = zv;
    tick();
    imem.ack  = 1'b0;
    imem.data = 16'($urandom);
    check("exec_ctl",  ctl_vec(),      exp_ctl(w));
    check("exec_req",  32'(imem.req),  32'd0);
    check("exec_busy", 32'(busy),      32'd1);
    run    = run_after;
    exp_pc = next_pc(w, exp_pc, zv);
    tick();
    if (run_after) begin
      check("next_req",  32'(imem.req),  32'd1);
      check("next_addr", 32'(imem.addr), 32'(exp_pc));
    end else begin
      expect_idle("post_exec_idle");
      check("idle_addr", 32'(imem.addr), 32'(exp_pc));
    end
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      imem.ack  = 1'b1;
      imem.data = 16'($urandom);
      tick();
      expect_idle("idle_ack_ignored");
      check("idle_addr_hold", 32'(imem.addr), 32'(exp_pc));
    end
    imem.ack = 1'b0;
  endtask

  task automatic start_run();
    run = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] w;
    reset     = 1'b1;
    run       = 1'b0;
    z         = 1'b0;
    imem.ack  = 1'b0;
    imem.data = '0;
    exp_pc    = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

    mem[8'h00] = enc(1, 1, 0, 8'h05);   // ADDI r1,#5
    mem[8'h01] = enc(7, 0, 0, 8'h20);   // BSW 0x20
    mem[8'h20] = enc(7, 1, 2, 8'h30);   // BSW 0x30
    mem[8'h21] = enc(6, 2, 0, 8'h40);   // BZ r2 0x40
    mem[8'h40] = enc(6, 2, 1, 8'h50);   // BZ r2 0x50
    mem[8'h41] = enc(0, 0, 0, 8'hFF);   // JMP 0xFF
    mem[8'hFF] = enc(1, 3, 1, 8'h07);   // ADDI at the top of the pc range

    tick();
    tick();
    expect_idle("reset");
    check("reset_addr", 32'(imem.addr), 32'd0);
    reset = 1'b0;
    idle_cycles(2);

    start_run();
    exec_instr(0, 1'b0, 1'b0, 1'b1);   // ADDI r1,#5 -> pc 1
    exec_instr(0, 1'b1, 1'b0, 1'b1);   // BSW taken  -> 0x20
    exec_instr(1, 1'b0, 1'b0, 1'b1);   // BSW not taken -> 0x21
    exec_instr(0, 1'b1, 1'b0, 1'b1);   // BZ taken   -> 0x40
    exec_instr(2, 1'b0, 1'b0, 1'b1);   // BZ not taken -> 0x41
    exec_instr(0, 1'b0, 1'b0, 1'b1);   // JMP 0xFF
    exec_instr(0, 1'b1, 1'b0, 1'b1);   // ADDI at 0xFF wraps to 0
    check("wrap_pc", 32'(exp_pc), 32'd0);
    exec_instr(3, 1'b0, 1'b0, 1'b1);   // ack delayed 3 cycles
    exec_instr(2, 1'b1, 1'b1, 1'b0);   // run dropped mid-FETCH, BSW -> 0x20
    idle_cycles(3);
    start_run();
    exec_instr(0, 1'b1, 1'b0, 1'b1);   // resumes at 0x20, taken -> 0x30

    // Reset in the middle of a stalled fetch.
    expect_fetch("pre_reset_fetch");
    reset = 1'b1;
    run   = 1'b0;
    tick();
    expect_idle("reset_fetch");
    check("reset_fetch_addr", 32'(imem.addr), 32'd0);
    reset  = 1'b0;
    exp_pc = '0;

    // Reset during EXEC of JMP 0x33: its controls show, the jump does not.
    mem[8'h00] = enc(0, 2, 3, 8'h33);
    start_run();
    expect_fetch("jmp_fetch");
    w         = mem[8'h00];
    imem.ack  = 1'b1;
    imem.data = w;
    tick();
    imem.ack  = 1'b0;
    check("jmp_exec_ctl", ctl_vec(), exp_ctl(w));
    reset = 1'b1;
    run   = 1'b0;
    tick();
    expect_idle("reset_exec");
    check("reset_exec_addr", 32'(imem.addr), 32'd0);
    reset = 1'b0;
    start_run();
    expect_fetch("after_reset_fetch");
    exec_instr(0, 1'b0, 1'b0, 1'b1);   // JMP 0x33 now completes
    check("jmp_target", 32'(exp_pc), 32'h33);

    // Randomized phase.
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int n_instr = 0; n_instr < 300; n_instr++) begin
      int   waits;
      logic zv;
      bit   drop;
      bit   cont;
      waits = int'($urandom_range(0, 3));
      zv    = 1'($urandom);
      drop  = ($urandom_range(0, 7) == 0);
      cont  = ($urandom_range(0, 5) != 0);
      exec_instr(waits, zv, drop, cont);
      if (!cont) begin
        idle_cycles(int'($urandom_range(0, 3)));
        start_run();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
